// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcode encodings and
// mul/div engine state encodings.
package ex_stage_pkg;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'h0,
      ALU_SUB   = 4'h1,
      ALU_AND   = 4'h2,
      ALU_OR    = 4'h3,
      ALU_XOR   = 4'h4,
      ALU_SLL   = 4'h5,
      ALU_SRL   = 4'h6,
      ALU_SRA   = 4'h7,
      ALU_SLT   = 4'h8,
      ALU_SLTU  = 4'h9,
      ALU_PASSB = 4'hA,
      ALU_MUL   = 4'hB,
      ALU_DIVU  = 4'hC,
      ALU_REMU  = 4'hD
   } alu_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   function automatic logic is_mul_div(input logic [3:0] op);
      return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
   endfunction

endpackage

// File: rtl/ex_stage_mul_div_unit.sv
// Iterative multiply / unsigned divide engine: one shift-add or
// restoring-subtract step per cycle, DATA_W steps per operation.
module mul_div_unit
   import ex_stage_pkg::*;
#(
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  alu_op_e           op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result
);

   localparam int unsigned CNT_W = $clog2(DATA_W);

   md_state_e         state, state_nxt;
   alu_op_e           op_q;
   // acc: product / remainder; x: multiplicand / quotient; y: multiplier / divisor
   logic [DATA_W-1:0] acc_q, x_q, y_q;
   logic [DATA_W-1:0] acc_nxt, x_nxt, y_nxt;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W:0]   rem_sh, rem_diff;
   logic              load;

   always_comb begin
      rem_sh   = {acc_q, x_q[DATA_W-1]};
      rem_diff = rem_sh - {1'b0, y_q};
      acc_nxt  = acc_q;
      x_nxt    = x_q;
      y_nxt    = y_q;
      if (op_q == ALU_MUL) begin
         acc_nxt = acc_q + (y_q[0] ? x_q : '0);
         x_nxt   = x_q << 1;
         y_nxt   = y_q >> 1;
      end else if (rem_sh >= {1'b0, y_q}) begin
         // divisor of zero always subtracts: quotient all ones, remainder = dividend
         acc_nxt = rem_diff[DATA_W-1:0];
         x_nxt   = {x_q[DATA_W-2:0], 1'b1};
      end else begin
         acc_nxt = rem_sh[DATA_W-1:0];
         x_nxt   = {x_q[DATA_W-2:0], 1'b0};
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      load      = 1'b0;
      case (state)
         MD_IDLE: begin
            if (start && rst) begin
               busy      = 1'b1;
               load      = 1'b1;
               state_nxt = MD_RUN;
            end
         end
         MD_RUN: begin
            busy = 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) state_nxt = MD_DONE;
         end
         MD_DONE: begin
            done      = 1'b1;
            state_nxt = MD_IDLE;
         end
         default: state_nxt = MD_IDLE;
      endcase
   end

   assign result = (op_q == ALU_DIVU) ? x_q : acc_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= MD_IDLE;
         op_q  <= ALU_ADD;
         acc_q <= '0;
         x_q   <= '0;
         y_q   <= '0;
         cnt_q <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            op_q  <= op;
            acc_q <= '0;
            x_q   <= a;
            y_q   <= b;
            cnt_q <= '0;
         end else if (state == MD_RUN) begin
            acc_q <= acc_nxt;
            x_q   <= x_nxt;
            y_q   <= y_nxt;
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand mux, single-cycle ALU, branch decision and
// EX/MEM control gating around the iterative mul/div engine.
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned REG_ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     ex_rs1_data,
   input  logic [DATA_W-1:0]     ex_rs2_data,
   input  logic [DATA_W-1:0]     ex_imm,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_reg_write,
   input  logic                  ex_alu_src,
   input  logic                  ex_mem_read,
   input  logic                  ex_mem_write,
   input  logic                  ex_mem_to_reg,
   input  logic                  ex_branch,
   input  logic                  ex_branch_ne,
   input  logic [3:0]            ex_alu_op,
   output logic                  ex_busy,
   output logic [DATA_W-1:0]     ex_result,
   output logic                  ex_zero,
   output logic                  ex_branch_taken,
   output logic [DATA_W-1:0]     ex_store_data,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic                  mem_reg_write,
   output logic                  mem_mem_read,
   output logic                  mem_mem_write,
   output logic                  mem_mem_to_reg
);

   alu_op_e           op;
   logic [DATA_W-1:0] op_a, op_b, diff, alu_res, md_result;
   logic [3:0]        shamt;
   logic              md_busy, md_done;

   assign op    = alu_op_e'(ex_alu_op);
   assign op_a  = ex_rs1_data;
   assign op_b  = ex_alu_src ? ex_imm : ex_rs2_data;
   assign diff  = op_a - op_b;
   assign shamt = op_b[3:0];

   always_comb begin
      alu_res = '0;
      case (op)
         ALU_ADD:   alu_res = op_a + op_b;
         ALU_SUB:   alu_res = diff;
         ALU_AND:   alu_res = op_a & op_b;
         ALU_OR:    alu_res = op_a | op_b;
         ALU_XOR:   alu_res = op_a ^ op_b;
         ALU_SLL:   alu_res = op_a << shamt;
         ALU_SRL:   alu_res = op_a >> shamt;
         ALU_SRA:   alu_res = DATA_W'($signed(op_a) >>> shamt);
         ALU_SLT:   alu_res[0] = $signed(op_a) < $signed(op_b);
         ALU_SLTU:  alu_res[0] = op_a < op_b;
         ALU_PASSB: alu_res = op_b;
         default:   alu_res = '0;
      endcase
   end

   mul_div_unit #(
      .DATA_W (DATA_W)
   ) u_mul_div (
      .clk    (clk),
      .rst    (rst),
      .start  (is_mul_div(ex_alu_op)),
      .op     (op),
      .a      (op_a),
      .b      (op_b),
      .busy   (md_busy),
      .done   (md_done),
      .result (md_result)
   );

   assign ex_busy         = md_busy;
   assign ex_result       = md_done ? md_result : alu_res;
   assign ex_zero         = (diff == '0);
   assign ex_branch_taken = ~md_busy & ((ex_branch & ex_zero) | (ex_branch_ne & ~ex_zero));
   assign ex_store_data   = ex_rs2_data;
   assign mem_rd          = ex_rd;
   assign mem_reg_write   = ex_reg_write  & ~md_busy;
   assign mem_mem_read    = ex_mem_read   & ~md_busy;
   assign mem_mem_write   = ex_mem_write  & ~md_busy;
   assign mem_mem_to_reg  = ex_mem_to_reg & ~md_busy;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
module tb_ex_stage;
   import ex_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] ex_rs1_data, ex_rs2_data, ex_imm;
   logic [3:0]  ex_rd;
   logic        ex_reg_write, ex_alu_src, ex_mem_read, ex_mem_write;
   logic        ex_mem_to_reg, ex_branch, ex_branch_ne;
   logic [3:0]  ex_alu_op;
   logic        ex_busy, ex_zero, ex_branch_taken;
   logic [15:0] ex_result, ex_store_data;
   logic [3:0]  mem_rd;
   logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ex_stage #(
      .DATA_W     (16),
      .REG_ADDR_W (4)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .ex_rs1_data     (ex_rs1_data),
      .ex_rs2_data     (ex_rs2_data),
      .ex_imm          (ex_imm),
      .ex_rd           (ex_rd),
      .ex_reg_write    (ex_reg_write),
      .ex_alu_src      (ex_alu_src),
      .ex_mem_read     (ex_mem_read),
      .ex_mem_write    (ex_mem_write),
      .ex_mem_to_reg   (ex_mem_to_reg),
      .ex_branch       (ex_branch),
      .ex_branch_ne    (ex_branch_ne),
      .ex_alu_op       (ex_alu_op),
      .ex_busy         (ex_busy),
      .ex_result       (ex_result),
      .ex_zero         (ex_zero),
      .ex_branch_taken (ex_branch_taken),
      .ex_store_data   (ex_store_data),
      .mem_rd          (mem_rd),
      .mem_reg_write   (mem_reg_write),
      .mem_mem_read    (mem_mem_read),
      .mem_mem_write   (mem_mem_write),
      .mem_mem_to_reg  (mem_mem_to_reg)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ctl = {reg_write, mem_read, mem_write, mem_to_reg, branch, branch_ne}
   task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] imm, input logic src, input logic [5:0] ctl);
      ex_alu_op     = op;
      ex_rs1_data   = a;
      ex_rs2_data   = b;
      ex_imm        = imm;
      ex_alu_src    = src;
      ex_reg_write  = ctl[5];
      ex_mem_read   = ctl[4];
      ex_mem_write  = ctl[3];
      ex_mem_to_reg = ctl[2];
      ex_branch     = ctl[1];
      ex_branch_ne  = ctl[0];
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] ctl_out();
      return {mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, ex_branch_taken};
   endfunction

   // Operation already on the inputs; measures the busy window and checks the DONE cycle.
   task automatic md_window(input string tag, input logic [15:0] exp_res);
      int   cnt      = 0;
      logic gate_bad = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!ex_busy) break;
         cnt++;
         if (ctl_out() !== 5'b0) gate_bad = 1'b1;
      end
      check({tag, " busy cycles"}, cnt, 17);
      check({tag, " gating"}, gate_bad, 1'b0);
      check({tag, " result"}, ex_result, exp_res);
      check({tag, " release"}, ctl_out(), 5'b11111);
   endtask

   initial begin
      rst   = 1'b0;
      ex_rd = 4'hA;
      drive(ALU_MUL, 16'd3, 16'd4, 16'd0, 1'b0, 6'b111111);
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", ex_busy, 1'b0);
      check("reset ctl passthrough", ctl_out(), 5'b11111);

      next_cycle();
      rst = 1'b1;
      drive(ALU_ADD, 16'h7FFF, 16'h0001, 16'h0000, 1'b0, 6'b100000);
      #1;
      check("add result", ex_result, 16'h8000);
      check("add zero", ex_zero, 1'b0);
      check("add busy", ex_busy, 1'b0);
      check("add mem_rd", mem_rd, 4'hA);
      check("add store", ex_store_data, 16'h0001);

      drive(ALU_ADD, 16'h0005, 16'h0009, 16'h0003, 1'b1, 6'b000000);
      #1;
      check("add imm", ex_result, 16'h0008);
      check("add imm store", ex_store_data, 16'h0009);
      drive(ALU_SUB, 16'h0005, 16'h0007, 16'h0000, 1'b0, 6'b000000);
      #1 check("sub wrap", ex_result, 16'hFFFE);
      drive(ALU_SRA, 16'h8000, 16'h0014, 16'h0000, 1'b0, 6'b000000);
      #1 check("sra", ex_result, 16'hF800);
      drive(ALU_SRL, 16'h8000, 16'h0014, 16'h0000, 1'b0, 6'b000000);
      #1 check("srl", ex_result, 16'h0800);
      drive(ALU_SLL, 16'h0001, 16'h000F, 16'h0000, 1'b0, 6'b000000);
      #1 check("sll", ex_result, 16'h8000);
      drive(ALU_XOR, 16'h00F0, 16'h0FF0, 16'h0000, 1'b0, 6'b000000);
      #1 check("xor", ex_result, 16'h0F00);
      drive(ALU_SLT, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 6'b000000);
      #1 check("slt", ex_result, 16'h0001);
      drive(ALU_SLTU, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 6'b000000);
      #1 check("sltu", ex_result, 16'h0000);
      drive(ALU_PASSB, 16'h1111, 16'h2222, 16'hBEEF, 1'b1, 6'b000000);
      #1 check("passb", ex_result, 16'hBEEF);
      drive(4'hE, 16'h1234, 16'h0001, 16'h0000, 1'b0, 6'b000000);
      #1;
      check("reserved result", ex_result, 16'h0000);
      check("reserved busy", ex_busy, 1'b0);

      drive(ALU_SUB, 16'h1234, 16'h1234, 16'h0000, 1'b0, 6'b000010);
      #1;
      check("beq zero", ex_zero, 1'b1);
      check("beq taken", ex_branch_taken, 1'b1);
      drive(ALU_SUB, 16'h1234, 16'h1234, 16'h0000, 1'b0, 6'b000001);
      #1 check("bne not taken", ex_branch_taken, 1'b0);
      drive(ALU_SUB, 16'h0005, 16'h0003, 16'h0000, 1'b0, 6'b000001);
      #1 check("bne taken", ex_branch_taken, 1'b1);

      next_cycle();
      drive(ALU_MUL, 16'd300, 16'd300, 16'd0, 1'b0, 6'b111111);
      md_window("mul", 16'h5F90);
      md_window("mul held", 16'h5F90);

      next_cycle();
      drive(ALU_DIVU, 16'd1000, 16'd7, 16'd0, 1'b0, 6'b111111);
      md_window("divu", 16'd142);
      next_cycle();
      drive(ALU_REMU, 16'd1000, 16'd0, 16'd7, 1'b1, 6'b111111);
      md_window("remu imm", 16'd6);
      next_cycle();
      drive(ALU_DIVU, 16'h00AB, 16'h0000, 16'd0, 1'b0, 6'b111111);
      md_window("divu by 0", 16'hFFFF);
      next_cycle();
      drive(ALU_REMU, 16'h00AB, 16'h0000, 16'd0, 1'b0, 6'b111111);
      md_window("remu by 0", 16'h00AB);

      next_cycle();
      drive(ALU_DIVU, 16'd1000, 16'd7, 16'd0, 1'b0, 6'b111111);
      repeat (5) @(posedge clk);
      #1;
      check("pre-reset busy", ex_busy, 1'b1);
      rst = 1'b0;
      #1;
      check("mid reset busy", ex_busy, 1'b0);
      check("mid reset ctl", ctl_out(), 5'b11111);
      next_cycle();
      check("held reset busy", ex_busy, 1'b0);
      drive(ALU_DIVU, 16'd9, 16'd2, 16'd0, 1'b0, 6'b111111);
      rst = 1'b1;
      md_window("divu after reset", 16'd4);

      next_cycle();
      drive(ALU_ADD, 16'h0010, 16'h0020, 16'h0000, 1'b0, 6'b100000);
      #1;
      check("post add busy", ex_busy, 1'b0);
      check("post add result", ex_result, 16'h0030);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
